// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: unsigned WIDTH-bit quotient and remainder,
// one quotient bit per clock, valid/ready on both sides.
module seq_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // One restoring step. The extra top bit of diff is the borrow, so the compare
    // stays exact even when the divisor is all ones.
    logic [WIDTH:0]   r_sh, r_next;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] q_next;

    assign r_sh   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign diff   = {1'b0, r_sh} - {2'b00, d_q};
    assign ge     = ~diff[WIDTH+1];
    assign r_next = ge ? diff[WIDTH:0] : r_sh;
    assign q_next = {q_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    quot_d  = q_next;
                    rem_d   = r_next[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=32): directed vectors,
// latency, backpressure, mid-operation reset and a short random run.
module tb_seq_restoring_divider;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   chk = 0;
    int   err = 0;
    bit   stall_en = 1'b0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk++; err++;
                    $display("FAIL unexpected_result: got q=0x%0h r=0x%0h with empty scoreboard",
                             quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    check("quotient", 68'(quotient), 68'(e.q));
                    check("remainder", 68'(remainder), 68'(e.r));
                    check("div_by_zero", 68'(div_by_zero), 68'(e.z));
                end
            end
        end
    end

    // Random out_ready stalls while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int n;
        exp_t e;
        e.q = eq; e.r = er; e.z = ez;
        sb.push_back(e);
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (!in_ready) begin
            chk++; err++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Issue with out_ready=1 and measure edges from acceptance to out_valid.
    task automatic issue_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic ez, input int lat);
        int n;
        issue(a, b, eq, er, ez);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", 68'(n), 68'(lat));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 68'({sb.size() != 0, busy}), 68'(0));
    endtask

    initial begin
        logic [W-1:0] a, b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {out_valid, busy, in_ready, div_by_zero, quotient, remainder}, 68'(0));
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 68'(in_ready), 68'(1));

        // Directed vectors
        issue_lat(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 1);
        wait_drain();
        issue_lat(32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
        wait_drain();
        issue_lat(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, W + 1);
        wait_drain();
        issue_lat(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, W + 1);
        wait_drain();
        issue_lat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, W + 1);
        wait_drain();
        issue_lat(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, W + 1);
        wait_drain();
        issue_lat(32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA, 32'd2, 1'b0, W + 1);
        wait_drain();

        // Backpressure: hold 10 cycles in DONE, pulse in_valid, then release
        out_ready = 1'b0;
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 4);
            dividend = 32'd9;
            divisor  = 32'd3;
            @(negedge clk);
            check("bp_hold", {out_valid, in_ready, div_by_zero, quotient, remainder},
                  {1'b1, 1'b0, 1'b0, 32'd14, 32'd2});
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle", 68'({busy, in_ready, out_valid}), 68'(3'b010));
        check("bp_no_extra", 68'(sb.size()), 68'(0));

        // Reset mid-CALC
        issue(32'd77, 32'd5, 32'd15, 32'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {out_valid, busy, in_ready, div_by_zero, quotient, remainder}, 68'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 68'(in_ready), 68'(1));
        issue_lat(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, W + 1);
        wait_drain();

        // Random back-to-back with stalls
        stall_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 17);
                2: b = a >> $urandom_range(0, 31);
                default: b = (i % 16 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            if (b == 0) issue(a, b, 32'hFFFF_FFFF, a, 1'b1);
            else        issue(a, b, a / b, a % b, 1'b0);
        end
        stall_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
